mux_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one 32:1 bit-select mux among 32 requesters. Requester i asserts `req[i]`. The block grants one requester at a time and drives the 5-bit mux select with the granted index. It also supplies a one-hot grant vector and bounds how long any single requester can hold the mux. It sits between the requester bank and the mux `Sel` input, and has no datapath of its own.

---
 rtl/mux_rr_arbiter.sv | 114 +++++++++++
 tb/tb_mux_rr_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin arbiter driving a 32:1 mux select
// Grants one of 32 requesters at a time, with a bounded hold and one dead cycle between grants.
module mux_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    input  logic [31:0] i_req,
    output logic [4:0]  o_sel,
    output logic [31:0] o_gnt,
    output logic        o_gnt_valid
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [4:0]  r_ptr;
    logic [4:0]  w_ptr_nxt;
    logic [7:0]  r_hold_cnt;
    logic [7:0]  w_hold_nxt;
    logic [4:0]  r_sel;
    logic [4:0]  w_sel_nxt;
    logic [31:0] r_gnt;
    logic [31:0] w_gnt_nxt;
    logic        r_gnt_valid;
    logic        w_gnt_valid_nxt;

    logic        w_found;
    logic [4:0]  w_winner;
    logic [4:0]  w_idx;
    logic        w_release;

    // Walk offsets from farthest to nearest so the closest set bit after r_ptr wins;
    // offset 32 wraps to r_ptr itself, giving the last winner the lowest priority.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_ptr;
        w_idx    = r_ptr;
        for (int i = 32; i >= 1; i--) begin
            w_idx = r_ptr + 5'(i);
            if (i_req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    assign w_release = !i_req[r_sel] ||
                       ((MAX_HOLD != 0) && (r_hold_cnt == HOLD_LIMIT));

    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_hold_nxt      = r_hold_cnt;
        w_sel_nxt       = r_sel;
        w_gnt_nxt       = r_gnt;
        w_gnt_valid_nxt = r_gnt_valid;
        case (r_state)
            ST_IDLE: begin
                w_gnt_nxt       = 32'd0;
                w_gnt_valid_nxt = 1'b0;
                if (i_en && w_found) begin
                    w_state_nxt     = ST_GRANT;
                    w_ptr_nxt       = w_winner;
                    w_sel_nxt       = w_winner;
                    w_gnt_nxt       = 32'd1 << w_winner;
                    w_gnt_valid_nxt = 1'b1;
                    w_hold_nxt      = 8'd1;
                end
            end
            ST_GRANT: begin
                if (w_release) begin
                    w_state_nxt     = ST_IDLE;
                    w_gnt_nxt       = 32'd0;
                    w_gnt_valid_nxt = 1'b0;
                    w_hold_nxt      = 8'd0;
                end else if (r_hold_cnt != 8'hFF) begin
                    w_hold_nxt = r_hold_cnt + 8'd1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_ptr       <= 5'd31;
            r_hold_cnt  <= 8'd0;
            r_sel       <= 5'd0;
            r_gnt       <= 32'd0;
            r_gnt_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_sel       <= w_sel_nxt;
            r_gnt       <= w_gnt_nxt;
            r_gnt_valid <= w_gnt_valid_nxt;
        end
    end

    assign o_sel       = r_sel;
    assign o_gnt       = r_gnt;
    assign o_gnt_valid = r_gnt_valid;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - testbench for mux_rr_arbiter
// Three instances (MAX_HOLD 2, 16, 0) share stimulus and are tracked by one reference model.
module tb_mux_rr_arbiter;

    localparam int MH [3] = '{2, 16, 0};

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] req;
    logic [4:0]  d_sel [3];
    logic [31:0] d_gnt [3];
    logic        d_gv  [3];

    int n_vec;
    int n_err;

    int m_ptr  [3];
    int m_sel  [3];
    int m_held [3];
    bit m_act  [3];

    mux_rr_arbiter #(.MAX_HOLD(2)) u_m2 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_req(req),
        .o_sel(d_sel[0]), .o_gnt(d_gnt[0]), .o_gnt_valid(d_gv[0])
    );
    mux_rr_arbiter #(.MAX_HOLD(16)) u_m16 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_req(req),
        .o_sel(d_sel[1]), .o_gnt(d_gnt[1]), .o_gnt_valid(d_gv[1])
    );
    mux_rr_arbiter #(.MAX_HOLD(0)) u_m0 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_req(req),
        .o_sel(d_sel[2]), .o_gnt(d_gnt[2]), .o_gnt_valid(d_gv[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural arbiter: pick nearest requester after the last winner, modulo 32.
    task automatic model_tick();
        for (int j = 0; j < 3; j++) begin
            if (rst) begin
                m_act[j] = 0; m_ptr[j] = 31; m_sel[j] = 0; m_held[j] = 0;
            end else if (!m_act[j]) begin
                if (en && req != 0) begin
                    bit found = 0;
                    for (int k = 1; k <= 32; k++) begin
                        int idx = (m_ptr[j] + k) % 32;
                        if (!found && req[idx]) begin
                            found = 1; m_act[j] = 1; m_sel[j] = idx;
                            m_ptr[j] = idx; m_held[j] = 1;
                        end
                    end
                end
            end else if (!req[m_sel[j]] || (MH[j] != 0 && m_held[j] == MH[j])) begin
                m_act[j] = 0; m_held[j] = 0;
            end else if (m_held[j] < 255) begin
                m_held[j] = m_held[j] + 1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; req = 32'hFFFF_FFFF;
        step();
        step();
        n_vec++;
        if ({d_sel[1], d_gnt[1], d_gv[1]} !== {5'd0, 32'd0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_state: got sel=%0d gnt=%h gv=%b expected sel=0 gnt=0 gv=0",
                     d_sel[1], d_gnt[1], d_gv[1]);
        end
        rst = 1'b0;
        step();
        for (int j = 0; j < 3; j++) begin
            n_vec++;
            if ({d_sel[j], d_gnt[j], d_gv[j]} !== {5'd0, 32'h0000_0001, 1'b1}) begin
                n_err++;
                $display("FAIL reset_first_grant[%0d]: got sel=%0d gnt=%h gv=%b expected sel=0 gnt=00000001 gv=1",
                         j, d_sel[j], d_gnt[j], d_gv[j]);
            end
        end
    endtask

    task automatic test_round_robin();
        int order [4] = '{3, 17, 31, 3};
        req = 32'd0; en = 1'b1;
        do_reset();
        req = (32'd1 << 3) | (32'd1 << 17) | (32'd1 << 31);
        for (int t = 1; t <= 12; t++) begin
            logic       exp_gv;
            logic [4:0] exp_sel;
            step();
            exp_gv  = (t % 3) != 0;
            exp_sel = 5'(order[(t - 1) / 3]);
            n_vec++;
            if (d_gv[0] !== exp_gv || d_sel[0] !== exp_sel ||
                d_gnt[0] !== (exp_gv ? (32'd1 << exp_sel) : 32'd0)) begin
                n_err++;
                $display("FAIL round_robin t=%0d: got sel=%0d gnt=%h gv=%b expected sel=%0d gv=%b",
                         t, d_sel[0], d_gnt[0], d_gv[0], exp_sel, exp_gv);
            end
        end
    endtask

    task automatic test_request_drop();
        req = 32'd0; en = 1'b1;
        do_reset();
        req = 32'd1 << 5;
        step();
        req = (32'd1 << 5) | (32'd1 << 4);
        step();
        step();
        req = 32'd1 << 4;
        step();
        n_vec++;
        if (d_gv[1] !== 1'b0 || d_sel[1] !== 5'd5 || d_gnt[1] !== 32'd0) begin
            n_err++;
            $display("FAIL req_drop_release: got sel=%0d gnt=%h gv=%b expected sel=5 gnt=0 gv=0",
                     d_sel[1], d_gnt[1], d_gv[1]);
        end
        step();
        n_vec++;
        if (d_gv[1] !== 1'b1 || d_sel[1] !== 5'd4 || d_gnt[1] !== 32'h0000_0010) begin
            n_err++;
            $display("FAIL req_drop_next: got sel=%0d gnt=%h gv=%b expected sel=4 gnt=00000010 gv=1",
                     d_sel[1], d_gnt[1], d_gv[1]);
        end
    endtask

    task automatic test_timeout();
        req = 32'd0; en = 1'b1;
        do_reset();
        req = 32'h0000_0100;
        for (int t = 1; t <= 34; t++) begin
            logic exp_gv;
            step();
            exp_gv = (t % 17) != 0;
            n_vec++;
            if (d_gv[1] !== exp_gv || d_sel[1] !== 5'd8) begin
                n_err++;
                $display("FAIL timeout t=%0d: got sel=%0d gv=%b expected sel=8 gv=%b",
                         t, d_sel[1], d_gv[1], exp_gv);
            end
        end
    endtask

    task automatic test_unlimited();
        req = 32'd0; en = 1'b1;
        do_reset();
        req = 32'd1 << 9;
        step();
        for (int t = 1; t <= 300; t++) begin
            n_vec++;
            if (d_gv[2] !== 1'b1 || d_sel[2] !== 5'd9) begin
                n_err++;
                $display("FAIL unlimited t=%0d: got sel=%0d gv=%b expected sel=9 gv=1",
                         t, d_sel[2], d_gv[2]);
            end
            step();
        end
    endtask

    task automatic test_enable();
        req = 32'd0; en = 1'b0;
        do_reset();
        req = (32'd1 << 28) | (32'd1 << 6);
        for (int t = 0; t < 5; t++) begin
            step();
            n_vec++;
            if (d_gv[1] !== 1'b0 || d_gnt[1] !== 32'd0) begin
                n_err++;
                $display("FAIL enable_off t=%0d: got gnt=%h gv=%b expected gnt=0 gv=0",
                         t, d_gnt[1], d_gv[1]);
            end
        end
        en = 1'b1;
        step();
        n_vec++;
        if (d_gv[1] !== 1'b1 || d_sel[1] !== 5'd6) begin
            n_err++;
            $display("FAIL enable_on: got sel=%0d gv=%b expected sel=6 gv=1", d_sel[1], d_gv[1]);
        end
        en = 1'b0;
        for (int t = 2; t <= 17; t++) begin
            step();
            n_vec++;
            if (d_gv[1] !== (t <= 16)) begin
                n_err++;
                $display("FAIL enable_mid_grant t=%0d: got gv=%b expected gv=%b",
                         t, d_gv[1], (t <= 16));
            end
        end
        en = 1'b1;
    endtask

    task automatic test_mid_reset();
        req = 32'd0; en = 1'b1;
        do_reset();
        req = 32'd1 << 20;
        step();
        step();
        step();
        step();
        n_vec++;
        if (d_gv[1] !== 1'b1 || d_sel[1] !== 5'd20) begin
            n_err++;
            $display("FAIL mid_reset_pre: got sel=%0d gv=%b expected sel=20 gv=1", d_sel[1], d_gv[1]);
        end
        rst = 1'b1;
        step();
        n_vec++;
        if (d_gv[1] !== 1'b0 || d_gnt[1] !== 32'd0 || d_sel[1] !== 5'd0) begin
            n_err++;
            $display("FAIL mid_reset: got sel=%0d gnt=%h gv=%b expected sel=0 gnt=0 gv=0",
                     d_sel[1], d_gnt[1], d_gv[1]);
        end
        rst = 1'b0;
        req = (32'd1 << 20) | (32'd1 << 2);
        step();
        n_vec++;
        if (d_gv[1] !== 1'b1 || d_sel[1] !== 5'd2) begin
            n_err++;
            $display("FAIL mid_reset_regrant: got sel=%0d gv=%b expected sel=2 gv=1", d_sel[1], d_gv[1]);
        end
    endtask

    task automatic test_random();
        req = 32'd0; en = 1'b1;
        do_reset();
        for (int t = 0; t < 3000; t++) begin
            if ($urandom_range(0, 3) == 0)
                req = $urandom() & $urandom() & $urandom();
            en  = ($urandom_range(0, 9) != 0);
            rst = ($urandom_range(0, 199) == 0);
            step();
            for (int j = 0; j < 3; j++) begin
                logic [31:0] exp_gnt;
                exp_gnt = m_act[j] ? (32'd1 << m_sel[j]) : 32'd0;
                n_vec++;
                if (d_sel[j] !== 5'(m_sel[j]) || d_gnt[j] !== exp_gnt || d_gv[j] !== m_act[j]) begin
                    n_err++;
                    $display("FAIL random[%0d] t=%0d: got sel=%0d gnt=%h gv=%b expected sel=%0d gnt=%h gv=%b",
                             j, t, d_sel[j], d_gnt[j], d_gv[j], m_sel[j], exp_gnt, m_act[j]);
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1; en = 1'b0; req = 32'd0;
        test_reset();
        test_round_robin();
        test_request_drop();
        test_timeout();
        test_unlimited();
        test_enable();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
